// File: rtl/aes_ctr_axil_pkg.sv
// Shared definitions for the AES-128 CTR AXI4-Lite register front end:
// register offsets, control/status bit positions, response codes, FSM states
// and small word-access helpers for the 128-bit operand registers.
// Optional feature macro used by the front end: AES_CTR_AUTO_INC_EN.
package aes_ctr_axil_pkg;

    // Byte offsets of the register map.
    localparam logic [31:0] OffCtrl   = 32'h00;
    localparam logic [31:0] OffStatus = 32'h04;
    localparam logic [31:0] OffKey    = 32'h10;
    localparam logic [31:0] OffIv     = 32'h20;
    localparam logic [31:0] OffDin    = 32'h30;
    localparam logic [31:0] OffDout   = 32'h40;

    localparam int unsigned CtrlStartBit   = 0;
    localparam int unsigned CtrlAutoIncBit = 1;
    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusDoneBit  = 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    typedef enum logic [2:0] {
        SelNone,
        SelCtrl,
        SelStatus,
        SelKey,
        SelIv,
        SelDin,
        SelDout
    } reg_sel_e;

    // Map a byte address onto a register group; byte lane bits are ignored.
    function automatic reg_sel_e decode_sel(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a == OffCtrl)               return SelCtrl;
        if (a == OffStatus)             return SelStatus;
        if (a[31:4] == OffKey[31:4])    return SelKey;
        if (a[31:4] == OffIv[31:4])     return SelIv;
        if (a[31:4] == OffDin[31:4])    return SelDin;
        if (a[31:4] == OffDout[31:4])   return SelDout;
        return SelNone;
    endfunction

    // Word 0 is the most significant word, matching NIST byte order.
    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    // Byte-strobed merge of one bus word into a 128-bit register.
    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                              input logic [31:0] data, input logic [3:0] strb);
        logic [31:0]  w;
        logic [127:0] r;
        w = get_word(v, idx);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        end
        r = v;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_ctr_axil_if.sv
// AXI4-Lite bus bundle between a bus master and the AES CTR register block.
interface aes_ctr_axil_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aes_ctr_axil_regs.sv
// AXI4-Lite register front end for the single-block AES-128 CTR engine.
// Holds KEY/IV/DIN operands, issues the engine start pulse, tracks BUSY/DONE
// and captures the engine result into DOUT.
// Optional feature: define AES_CTR_AUTO_INC_EN to enable CTRL.AUTO_INC, which
// bumps IV by one (mod 2^128) whenever a result is captured.
module aes_ctr_axil_regs
    import aes_ctr_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    aes_ctr_axil_if.slave s_axi,
    output logic          eng_start_o,
    output logic [127:0]  eng_key_o,
    output logic [127:0]  eng_iv_o,
    output logic [127:0]  eng_data_o,
    input  logic [127:0]  eng_data_out_i,
    input  logic          eng_done_i
);

    // Write channel state.
    w_state_e          w_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    // Read channel state.
    r_state_e          r_state_q;
    logic              arready_q, rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    // Register file and engine control.
    logic [127:0] key_q, key_d;
    logic [127:0] iv_q, iv_d;
    logic [127:0] din_q, din_d;
    logic [127:0] dout_q, dout_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         auto_inc_q, auto_inc_d;
    logic         eng_start_q, eng_start_d;

    logic         aw_hs, w_hs, wr_commit;
    reg_sel_e     wsel, rsel;
    logic [1:0]   widx, ridx;
    logic [1:0]   wr_resp, rd_resp;
    logic [31:0]  rd_data;
    logic         start_req, done_clr, done_set;

    assign aw_hs     = s_axi.awvalid && awready_q;
    assign w_hs      = s_axi.wvalid && wready_q;
    assign wr_commit = (w_state_q == WIdle) && aw_held_q && w_held_q;
    assign wsel      = decode_sel(32'(aw_addr_q));
    assign widx      = aw_addr_q[3:2];
    assign rsel      = decode_sel(32'(s_axi.araddr));
    assign ridx      = s_axi.araddr[3:2];
    assign done_set  = busy_q && eng_done_i;

    // Register write decode, START/DONE handling and result capture.
    always_comb begin
        key_d       = key_q;
        iv_d        = iv_q;
        din_d       = din_q;
        dout_d      = dout_q;
        auto_inc_d  = auto_inc_q;
        wr_resp     = RespOkay;
        start_req   = 1'b0;
        done_clr    = 1'b0;
        if (wr_commit) begin
            unique case (wsel)
                SelCtrl: begin
                    start_req = wstrb_q[0] && wdata_q[CtrlStartBit];
`ifdef AES_CTR_AUTO_INC_EN
                    if (wstrb_q[0]) auto_inc_d = wdata_q[CtrlAutoIncBit];
`endif
                end
                SelStatus: done_clr = wstrb_q[0] && wdata_q[StatusDoneBit];
                SelKey: begin
                    if (busy_q) wr_resp = RespSlvErr;
                    else        key_d = put_word(key_q, widx, wdata_q, wstrb_q);
                end
                SelIv: begin
                    if (busy_q) wr_resp = RespSlvErr;
                    else        iv_d = put_word(iv_q, widx, wdata_q, wstrb_q);
                end
                SelDin: begin
                    if (busy_q) wr_resp = RespSlvErr;
                    else        din_d = put_word(din_q, widx, wdata_q, wstrb_q);
                end
                default: wr_resp = RespSlvErr;
            endcase
        end
        // IV bus writes are rejected while BUSY, so this never collides with one.
        if (done_set) begin
            dout_d = eng_data_out_i;
`ifdef AES_CTR_AUTO_INC_EN
            if (auto_inc_q) iv_d = iv_q + 128'd1;
`endif
        end
`ifndef AES_CTR_AUTO_INC_EN
        auto_inc_d = 1'b0;
`endif
        eng_start_d = start_req && !busy_q;
        if (done_set)         busy_d = 1'b0;
        else if (eng_start_d) busy_d = 1'b1;
        else                  busy_d = busy_q;
        // A completion in the same cycle as a W1C keeps DONE set.
        done_d = done_set || (done_q && !done_clr);
    end

    // Read data mux; unmapped addresses return SLVERR with zero data.
    always_comb begin
        rd_data = '0;
        rd_resp = RespOkay;
        unique case (rsel)
            SelCtrl:   rd_data[CtrlAutoIncBit] = auto_inc_q;
            SelStatus: begin
                rd_data[StatusBusyBit] = busy_q;
                rd_data[StatusDoneBit] = done_q;
            end
            SelKey:    rd_data = get_word(key_q, ridx);
            SelIv:     rd_data = get_word(iv_q, ridx);
            SelDin:    rd_data = get_word(din_q, ridx);
            SelDout:   rd_data = get_word(dout_q, ridx);
            default:   rd_resp = RespSlvErr;
        endcase
    end

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    if (wr_commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp;
                        w_state_q <= WResp;
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_addr_q <= s_axi.awaddr;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axi.wdata;
                            wstrb_q  <= s_axi.wstrb;
                        end
                        awready_q <= !(aw_held_q || aw_hs);
                        wready_q  <= !(w_held_q || w_hs);
                    end
                end
                WResp: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
            endcase
        end
    end

    // Read FSM: accept one address, then hold data until the master takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    if (s_axi.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                        r_state_q <= RData;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RData: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= RIdle;
                    end
                end
            endcase
        end
    end

    // Register file and engine control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '0;
            iv_q        <= '0;
            din_q       <= '0;
            dout_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            auto_inc_q  <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            iv_q        <= iv_d;
            din_q       <= din_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            auto_inc_q  <= auto_inc_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign eng_start_o = eng_start_q;
    assign eng_key_o   = key_q;
    assign eng_iv_o    = iv_q;
    assign eng_data_o  = din_q;

endmodule

// File: tb/tb_aes_ctr_axil_regs.sv
// Scoreboard bench for aes_ctr_axil_regs: stimulus tasks queue the expected
// B/R responses and engine operands; a negedge monitor pops and compares.
// Expectations follow AES_CTR_AUTO_INC_EN when it is defined.
module tb_aes_ctr_axil_regs;
    import aes_ctr_axil_pkg::*;

`ifdef AES_CTR_AUTO_INC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        string       name;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         eng_start;
    logic [127:0] eng_key, eng_iv, eng_data;
    logic [127:0] eng_data_out = '0;
    logic         eng_done = 1'b0;

    aes_ctr_axil_if #(.ADDR_W(8)) bus ();

    aes_ctr_axil_regs #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axi          (bus),
        .eng_start_o    (eng_start),
        .eng_key_o      (eng_key),
        .eng_iv_o       (eng_iv),
        .eng_data_o     (eng_data),
        .eng_data_out_i (eng_data_out),
        .eng_done_i     (eng_done)
    );

    always #5 clk = ~clk;

    exp_t exp_b[$];
    exp_t exp_r[$];
    op_t  exp_s[$];
    exp_t mon_e;
    op_t  mon_op;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [127:0] key_m, iv_m, din_m;
    localparam logic [127:0] Dout1 = 128'hdecf29db103a4c3dc3e38ed70aa9a6d0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void report_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [31:0] wd(input logic [127:0] v, input int i);
        return v[127-32*i -: 32];
    endfunction

    // Monitor: every response and start pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) report_fail("unexpected bvalid");
                else begin
                    mon_e = exp_b.pop_front();
                    check({mon_e.name, " bresp"}, 128'(bus.bresp), 128'(mon_e.resp));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) report_fail("unexpected rvalid");
                else begin
                    mon_e = exp_r.pop_front();
                    check({mon_e.name, " rresp"}, 128'(bus.rresp), 128'(mon_e.resp));
                    check({mon_e.name, " rdata"}, 128'(bus.rdata), 128'(mon_e.data));
                end
            end
            if (eng_start) begin
                if (exp_s.size() == 0) report_fail("unexpected eng_start");
                else begin
                    mon_op = exp_s.pop_front();
                    check("eng_key at start", eng_key, mon_op.key);
                    check("eng_iv at start", eng_iv, mon_op.iv);
                    check("eng_data at start", eng_data, mon_op.din);
                end
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] r, input string n, input int aw_dly = 0,
                             input int w_dly = 0);
        exp_t e;
        bit   aw_pend = 1'b1;
        bit   w_pend  = 1'b1;
        e.resp = r;
        e.data = '0;
        e.name = n;
        exp_b.push_back(e);
        for (int k = 0; k < 60 && (aw_pend || w_pend); k++) begin
            @(negedge clk);
            bus.awaddr  = a;
            bus.wdata   = d;
            bus.wstrb   = s;
            bus.awvalid = aw_pend && (k >= aw_dly);
            bus.wvalid  = w_pend && (k >= w_dly);
            #1;
            if (bus.awvalid && bus.awready) aw_pend = 1'b0;
            if (bus.wvalid && bus.wready)   w_pend = 1'b0;
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (aw_pend || w_pend) report_fail({n, " aw/w handshake timeout"});
        for (int k = 0; k < 20 && exp_b.size() != 0; k++) @(negedge clk);
        if (exp_b.size() != 0) begin
            report_fail({n, " bvalid timeout"});
            exp_b.delete();
        end
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r,
                            input string n);
        exp_t e;
        bit   pend = 1'b1;
        e.resp = r;
        e.data = d;
        e.name = n;
        exp_r.push_back(e);
        for (int k = 0; k < 40 && pend; k++) begin
            @(negedge clk);
            bus.araddr  = a;
            bus.arvalid = 1'b1;
            #1;
            if (bus.arready) pend = 1'b0;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        if (pend) report_fail({n, " ar handshake timeout"});
        for (int k = 0; k < 20 && exp_r.size() != 0; k++) @(negedge clk);
        if (exp_r.size() != 0) begin
            report_fail({n, " rvalid timeout"});
            exp_r.delete();
        end
    endtask

    task automatic write128(input logic [7:0] base, input logic [127:0] v, input string n);
        for (int i = 0; i < 4; i++) axi_write(base + 8'(4*i), wd(v, i), 4'hf, RespOkay, n);
    endtask

    task automatic start_engine(input logic [31:0] ctrl);
        op_t op;
        op.key = key_m;
        op.iv  = iv_m;
        op.din = din_m;
        exp_s.push_back(op);
        axi_write(8'(OffCtrl), ctrl, 4'hf, RespOkay, "start");
    endtask

    task automatic inject_done(input logic [127:0] v);
        @(negedge clk);
        eng_data_out = v;
        eng_done     = 1'b1;
        @(negedge clk);
        eng_done     = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        key_m = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        iv_m  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        din_m = 128'h3243f6a8885a308d313198a2e0370734;

        // Reset state.
        repeat (3) @(negedge clk);
        check("awready in reset", 128'(bus.awready), 128'd0);
        check("bvalid in reset", 128'(bus.bvalid), 128'd0);
        check("eng_start in reset", 128'(eng_start), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("awready after reset", 128'(bus.awready), 128'd1);
        check("arready after reset", 128'(bus.arready), 128'd1);
        axi_read(8'(OffStatus), 32'h0, RespOkay, "status reset");
        axi_read(8'(OffCtrl), 32'h0, RespOkay, "ctrl reset");
        axi_read(8'(OffKey), 32'h0, RespOkay, "key0 reset");

        // NIST operands, one run, result readback.
        write128(8'(OffKey), key_m, "key");
        write128(8'(OffIv), iv_m, "iv");
        write128(8'(OffDin), din_m, "din");
        start_engine(32'h1);
        axi_read(8'(OffStatus), 32'h1, RespOkay, "status busy");
        repeat (3) @(negedge clk);
        inject_done(Dout1);
        axi_read(8'(OffStatus), 32'h2, RespOkay, "status done");
        for (int i = 0; i < 4; i++)
            axi_read(8'(OffDout) + 8'(4*i), wd(Dout1, i), RespOkay, "dout");
        axi_read(8'(OffIv) + 8'hc, 32'hfcfdfeff, RespOkay, "iv3 no auto_inc");

        // DONE W1C, and set winning over a simultaneous clear.
        axi_write(8'(OffStatus), 32'h2, 4'hf, RespOkay, "w1c done");
        axi_read(8'(OffStatus), 32'h0, RespOkay, "status after w1c");
        start_engine(32'h1);
        fork
            axi_write(8'(OffStatus), 32'h2, 4'hf, RespOkay, "w1c with done");
            begin
                @(negedge clk);
                @(negedge clk);
                eng_data_out = Dout1;
                eng_done     = 1'b1;
                @(negedge clk);
                eng_done     = 1'b0;
            end
        join
        axi_read(8'(OffStatus), 32'h2, RespOkay, "done set wins");
        axi_write(8'(OffStatus), 32'h2, 4'hf, RespOkay, "w1c later");
        axi_read(8'(OffStatus), 32'h0, RespOkay, "done cleared");

        // Error responses and START while BUSY.
        start_engine(32'h1);
        axi_write(8'(OffKey), 32'hdeadbeef, 4'hf, RespSlvErr, "key0 while busy");
        axi_write(8'(OffCtrl), 32'h1, 4'hf, RespOkay, "start while busy");
        inject_done(Dout1);
        axi_read(8'(OffKey), 32'h2b7e1516, RespOkay, "key0 kept");
        axi_read(8'h80, 32'h0, RespSlvErr, "read unmapped");
        axi_write(8'(OffDout), 32'h1, 4'hf, RespSlvErr, "write dout");
        axi_write(8'h08, 32'h1, 4'hf, RespSlvErr, "write unmapped");

        // AW/W ordering and byte strobes on DIN.
        axi_write(8'(OffDin) + 8'hc, 32'h11223344, 4'hf, RespOkay, "w before aw", 3, 0);
        axi_write(8'(OffDin) + 8'hc, 32'haabbccdd, 4'b0101, RespOkay, "aw with w strb");
        axi_read(8'(OffDin) + 8'hc, 32'h11bb33dd, RespOkay, "din3 strobed");
        axi_write(8'(OffDin) + 8'h8, 32'h55667788, 4'hf, RespOkay, "aw before w", 0, 2);
        axi_read(8'(OffDin) + 8'h8, 32'h55667788, RespOkay, "din2 aw first");
        din_m[31:0]  = 32'h11bb33dd;
        din_m[63:32] = 32'h55667788;

        // AUTO_INC runs (no-op unless the feature is built in).
        axi_write(8'(OffCtrl), 32'h2, 4'hf, RespOkay, "ctrl auto_inc");
        axi_read(8'(OffCtrl), AutoInc ? 32'h2 : 32'h0, RespOkay, "ctrl readback");
        start_engine(32'h3);
        inject_done(Dout1);
        axi_read(8'(OffIv) + 8'hc, AutoInc ? 32'hfcfdff00 : 32'hfcfdfeff, RespOkay, "iv3 after run");
        iv_m = '1;
        write128(8'(OffIv), iv_m, "iv ones");
        start_engine(32'h3);
        inject_done(Dout1);
        for (int i = 0; i < 4; i++)
            axi_read(8'(OffIv) + 8'(4*i), AutoInc ? 32'h0 : 32'hffffffff, RespOkay, "iv wrap");

        // Reset while BUSY, then a late completion.
        start_engine(32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("eng_start during reset", 128'(eng_start), 128'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        inject_done(Dout1);
        axi_read(8'(OffStatus), 32'h0, RespOkay, "status after rst");
        for (int i = 0; i < 4; i++)
            axi_read(8'(OffDout) + 8'(4*i), 32'h0, RespOkay, "dout after rst");
        check("eng_key after rst", eng_key, 128'd0);

        repeat (5) @(negedge clk);
        if (exp_s.size() != 0) report_fail("eng_start never seen");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ctr_axil_regs.md
# aes_ctr_axil_regs

AXI4-Lite responder (slave) register front end for the single-block AES-128 CTR engine. Bus masters program key, IV/counter and one 128-bit data block, pulse START, poll or clear DONE, and read back the result. The block drives the engine's start/key/iv/data inputs and captures its data_out on done. The engine itself is instantiated beside this block in `aes_ctr_axil_top`.

## Interface
- ADDR_W, 8, AXI4-Lite address width (byte address, bits [1:0] ignored)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel (wstrb honoured per byte)
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
- eng_start  out  1  one-cycle start pulse to engine
- eng_key/eng_iv/eng_data  out  128 each  engine operands (KEY, IV, DIN registers)
- eng_data_out  in  128  engine result
- eng_done  in  1  engine completion pulse

## Operation
- Register map (word 0 = bits [127:96], big-endian to match NIST vectors):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 AUTO_INC (RW)
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear)
  - 0x10–0x1C KEY[0..3], 0x20–0x2C IV[0..3], 0x30–0x3C DIN[0..3] (RW)
  - 0x40–0x4C DOUT[0..3] (RO)
- AW and W are captured independently, in either order; the register write commits in the cycle both are held; then bvalid asserts.
- BRESP: OKAY; SLVERR for unmapped address, write to RO register, or write to KEY/IV/DIN while BUSY (data discarded).
- RRESP: OKAY; SLVERR with rdata=0 for unmapped address.
- Write FSM: W_IDLE (awready/wready per unheld channel) → W_RESP (bvalid until bready) → W_IDLE. Read FSM: R_IDLE (arready=1) → R_DATA (rvalid until rready) → R_IDLE. The read and write channels run concurrently.
- START with BUSY=0: eng_start pulses; BUSY sets. START with BUSY=1: ignored, response OKAY.
- eng_done with BUSY=1: DOUT←eng_data_out, BUSY clears, DONE sets. eng_done with BUSY=0 is ignored.
- DONE set and W1C in the same cycle: set wins.

## Timing
- Reset values: all readies, bvalid, rvalid, eng_start = 0; bresp/rresp/rdata = 0; all registers = 0. Readies assert in the first cycle after rst deasserts.
- eng_start is registered: it is high in the cycle after the CTRL write commits. BUSY reads 1 from that same cycle.
- DOUT/DONE/BUSY update in the cycle after eng_done is sampled.
- Read latency: rvalid in the cycle after the AR handshake; rdata holds stable until rready.
- rst asserted mid-operation: all state clears immediately. A late eng_done is ignored because BUSY=0.

## Configuration
- AES_CTR_AUTO_INC_EN defined:
  - With CTRL.AUTO_INC=1, IV increments by 1 modulo 2^128 in the same cycle DOUT is captured (all-ones wraps to zero).
  - A bus write to IV in that same cycle cannot occur, because IV writes are rejected while BUSY.
- AES_CTR_AUTO_INC_EN undefined:
  - CTRL bit1 is read-as-zero and writes to it are ignored.
  - IV never changes except by bus write.

## Structure
- Package `aes_ctr_axil_pkg`:
  - register offset localparams
  - STATUS/CTRL bit indices
  - AXI resp codes (OKAY=2'b00, SLVERR=2'b10)
  - FSM state typedefs
- No sub-module inside this block. The 128-bit incrementer stays inline.

## Test plan
- Write KEY=2b7e151628aed2a6abf7158809cf4f3c, IV=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, DIN=3243f6a8885a308d313198a2e0370734, then START, then poll DONE → DOUT reads decf29db, 103a4c3d, c3e38ed7, 0aa9a6d0; BUSY=0.
- W before AW by 3 cycles, and AW/W in the same cycle → both commit once, single bvalid, BRESP=OKAY.
- Write to KEY[0] while BUSY, and read of 0x80 → BRESP=SLVERR with KEY unchanged; RRESP=SLVERR with rdata=0.
- AUTO_INC=1 run (macro on) → IV[3] reads fcfdff00. IV=all ones → IV reads 0 after done. Macro off → IV unchanged and CTRL reads 0x0.
- Write STATUS=0x2 in the same cycle as eng_done → DONE reads 1. A later write of 0x2 → DONE reads 0.
- Assert rst while BUSY, then release, then inject eng_done → BUSY=0, DONE=0, DOUT=0, and no eng_start.
